// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the 2-input gate test sequencer.
// TRUTH bit index is {a,b}.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/hold_timer.sv
// Counts the cycles a test vector has been held; flags the last cycle of the hold.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tc_c = en && (cnt_q == LAST);

endmodule

// File: rtl/gate_test_seq.sv
// Drives the four input vectors of a 2-input gate, compares its output against
// a truth table and reports per-vector mismatches.
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [3:0]  TRUTH       = TT_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    state_t     state_q, state_n;
    logic [1:0] idx_q, idx_n;
    logic [1:0] ab_q, ab_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       pass_q, pass_n;
    logic [2:0] err_q, err_n;
    logic [3:0] fail_q, fail_n;
    logic       tmr_clear, tmr_en, tmr_tc_c;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .en    (tmr_en),
        .tc_c  (tmr_tc_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ab_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            ab_q    <= ab_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            err_q   <= err_n;
            fail_q  <= fail_n;
        end
    end

    // Outputs are computed for the next cycle so they leave the flops aligned with the state.
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        ab_n      = 2'b00;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        pass_n    = pass_q;
        err_n     = err_q;
        fail_n    = fail_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_DRIVE;
                    idx_n     = 2'd0;
                    busy_n    = 1'b1;
                    pass_n    = 1'b0;
                    err_n     = '0;
                    fail_n    = '0;
                    tmr_clear = 1'b1;
                end
            end
            ST_DRIVE: begin
                tmr_en = 1'b1;
                busy_n = 1'b1;
                ab_n   = idx_q;
                if (tmr_tc_c) begin
                    tmr_clear = 1'b1;
                    if (y_in != TRUTH[idx_q]) begin
                        err_n         = err_q + 3'd1;
                        fail_n[idx_q] = 1'b1;
                    end
                    if (idx_q == 2'd3) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        ab_n    = 2'b00;
                        pass_n  = (err_n == 3'd0);
                    end else begin
                        idx_n = idx_q + 2'd1;
                        ab_n  = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
